// File: rtl/stack_scheduler.sv
// stack_scheduler: shares one LIFO stack between two writers (W0, W1) and two
// readers (R0, R1). One stack transaction runs at a time. Requesters are
// granted round-robin, masked by full/empty. Stalled handshakes are aborted
// by a watchdog.
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   wr_req, wr_data0/1     writer request levels and push data
//   wr_ack                 one-cycle pulse per writer when its push completes
//   rd_req                 reader request levels
//   rd_ack, rd_data        one-cycle pulse per reader; popped word (held)
//   tx_rdy, tx_done,       four-phase push handshake toward the stack
//   in_data
//   rx_rdy, rx_done,       four-phase pop handshake toward the stack
//   out_data
//   empty, full            stack status, used only for arbitration
//   busy                   FSM not in IDLE
//   err, err_id            one-cycle watchdog abort pulse and the aborted slot
//
// State table:
//   IDLE      | arbitrate among eligible requesters
//   WR_ASSERT | tx_rdy high, waiting for tx_done=1
//   WR_REL    | tx_rdy low, waiting for tx_done=0
//   RD_WAIT   | waiting for rx_rdy=1
//   RD_REL    | rx_done high, waiting for rx_rdy=0
//   DONE      | ack pulse cycle
//   ERR       | watchdog abort pulse cycle
module stack_scheduler #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       wr_req,
    input  logic [WIDTH-1:0] wr_data0,
    input  logic [WIDTH-1:0] wr_data1,
    output logic [1:0]       wr_ack,
    input  logic [1:0]       rd_req,
    output logic [1:0]       rd_ack,
    output logic [WIDTH-1:0] rd_data,
    output logic             tx_rdy,
    input  logic             tx_done,
    output logic [WIDTH-1:0] in_data,
    input  logic             rx_rdy,
    output logic             rx_done,
    input  logic [WIDTH-1:0] out_data,
    input  logic             empty,
    input  logic             full,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_id
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ASSERT,
        WR_REL,
        RD_WAIT,
        RD_REL,
        DONE,
        ERR
    } state_t;

    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT - 1);

    state_t        state;
    logic [1:0]    last;
    logic [1:0]    slot;
    logic [WW-1:0] wdog;

    logic [3:0] elig;
    logic       win_valid;
    logic [1:0] win;
    logic [1:0] cand;
    logic       in_wait;
    logic       exit_cond;

    // Slot order: 0=W0, 1=W1, 2=R0, 3=R1.
    assign elig = {rd_req[1] & ~empty, rd_req[0] & ~empty,
                   wr_req[1] & ~full,  wr_req[0] & ~full};

    // Scan starts just after the last winner; 2-bit addition provides the wrap.
    always_comb begin
        win_valid = 1'b0;
        win       = last;
        cand      = last;
        for (int i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!win_valid && elig[cand]) begin
                win_valid = 1'b1;
                win       = cand;
            end
        end
    end

    always_comb begin
        in_wait   = 1'b0;
        exit_cond = 1'b0;
        case (state)
            WR_ASSERT: begin in_wait = 1'b1; exit_cond = tx_done;  end
            WR_REL:    begin in_wait = 1'b1; exit_cond = !tx_done; end
            RD_WAIT:   begin in_wait = 1'b1; exit_cond = rx_rdy;   end
            RD_REL:    begin in_wait = 1'b1; exit_cond = !rx_rdy;  end
            default:   begin in_wait = 1'b0; exit_cond = 1'b0;     end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 2'd3;
            slot    <= 2'd0;
            wdog    <= '0;
            tx_rdy  <= 1'b0;
            rx_done <= 1'b0;
            in_data <= '0;
            rd_data <= '0;
            wr_ack  <= 2'b00;
            rd_ack  <= 2'b00;
            busy    <= 1'b0;
            err     <= 1'b0;
            err_id  <= 2'd0;
        end else begin
            wr_ack <= 2'b00;
            rd_ack <= 2'b00;
            err    <= 1'b0;
            if (in_wait && !exit_cond) begin
                if (wdog == WDOG_MAX) begin
                    state   <= ERR;
                    tx_rdy  <= 1'b0;
                    rx_done <= 1'b0;
                    err     <= 1'b1;
                    err_id  <= slot;
                    wdog    <= '0;
                end else begin
                    wdog <= wdog + 1'b1;
                end
            end else begin
                wdog <= '0;
                case (state)
                    IDLE: begin
                        if (win_valid) begin
                            last <= win;
                            slot <= win;
                            busy <= 1'b1;
                            if (!win[1]) begin
                                state   <= WR_ASSERT;
                                tx_rdy  <= 1'b1;
                                in_data <= win[0] ? wr_data1 : wr_data0;
                            end else begin
                                state <= RD_WAIT;
                            end
                        end
                    end
                    WR_ASSERT: begin
                        state  <= WR_REL;
                        tx_rdy <= 1'b0;
                    end
                    WR_REL: begin
                        state           <= DONE;
                        wr_ack[slot[0]] <= 1'b1;
                    end
                    RD_WAIT: begin
                        state   <= RD_REL;
                        rd_data <= out_data;
                        rx_done <= 1'b1;
                    end
                    RD_REL: begin
                        state           <= DONE;
                        rx_done         <= 1'b0;
                        rd_ack[slot[0]] <= 1'b1;
                    end
                    default: begin
                        // DONE and ERR both last one cycle.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stack_scheduler.sv
module tb_stack_scheduler;

    localparam int WIDTH = 8;
    localparam int TIMEOUT = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       wr_req;
    logic [WIDTH-1:0] wr_data0, wr_data1;
    logic [1:0]       wr_ack;
    logic [1:0]       rd_req;
    logic [1:0]       rd_ack;
    logic [WIDTH-1:0] rd_data;
    logic             tx_rdy;
    logic             tx_done;
    logic [WIDTH-1:0] in_data;
    logic             rx_rdy;
    logic             rx_done;
    logic [WIDTH-1:0] out_data;
    logic             empty, full;
    logic             busy, err;
    logic [1:0]       err_id;

    int errors = 0;
    int checks = 0;

    // Behavioural stack on the far side of the handshakes.
    logic [WIDTH-1:0] env_q[$];
    bit               stall_tx = 0;

    // Reference: expected stack contents and round-robin pointer.
    logic [WIDTH-1:0] ref_q[$];
    int               last_m = 3;

    stack_scheduler #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
        .tx_rdy(tx_rdy), .tx_done(tx_done), .in_data(in_data),
        .rx_rdy(rx_rdy), .rx_done(rx_done), .out_data(out_data),
        .empty(empty), .full(full),
        .busy(busy), .err(err), .err_id(err_id)
    );

    always #5 clk = ~clk;

    initial begin
        tx_done  = 1'b0;
        rx_rdy   = 1'b0;
        out_data = '0;
        empty    = 1'b1;
        full     = 1'b0;
    end

    always @(posedge clk) begin
        if (tx_rdy && !tx_done && !stall_tx) begin
            env_q.push_back(in_data);
            tx_done <= 1'b1;
        end else if (!tx_rdy && tx_done) begin
            tx_done <= 1'b0;
        end
        if (rx_done && rx_rdy) begin
            void'(env_q.pop_back());
            rx_rdy <= 1'b0;
        end else if (!rx_done && env_q.size() > 0) begin
            rx_rdy <= 1'b1;
        end else if (env_q.size() == 0) begin
            rx_rdy <= 1'b0;
        end
        full     <= (env_q.size() >= DEPTH);
        empty    <= (env_q.size() == 0);
        out_data <= (env_q.size() > 0) ? env_q[$] : '0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int predict();
        bit [3:0] el;
        int s;
        el[0] = wr_req[0] && (ref_q.size() < DEPTH);
        el[1] = wr_req[1] && (ref_q.size() < DEPTH);
        el[2] = rd_req[0] && (ref_q.size() > 0);
        el[3] = rd_req[1] && (ref_q.size() > 0);
        for (int k = 1; k <= 4; k++) begin
            s = (last_m + k) % 4;
            if (el[s]) return s;
        end
        return -1;
    endfunction

    // Runs one arbitration plus transaction; starts and ends at a negedge in IDLE.
    task automatic run_txn(input string tag, input bit reraise);
        int w, start, n;
        bit got, seen_tx, overlap;
        logic [WIDTH-1:0] wdat;
        w = predict();
        if (w < 0) begin
            repeat (4) begin
                @(negedge clk);
                chk({tag, "_idle_busy"}, 32'(busy), 0);
            end
            return;
        end
        wdat = (w == 1) ? wr_data1 : wr_data0;
        start = -1; got = 0; seen_tx = 0; overlap = 0;
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            if (tx_rdy && rx_done) overlap = 1;
            if (busy && start < 0) start = n;
            if (tx_rdy && !seen_tx) begin
                seen_tx = 1;
                chk({tag, "_in_data"}, 32'(in_data), 32'(wdat));
            end
            if (wr_ack != 0 || rd_ack != 0 || err) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        chk({tag, "_ack"}, 32'({rd_ack, wr_ack}), 32'(1 << w));
        chk({tag, "_overlap"}, 32'(overlap), 0);
        last_m = w;
        if (w < 2) begin
            chk({tag, "_wr_latency"}, 32'(n - start), 4);
            ref_q.push_back(wdat);
            wr_req[w] = 1'b0;
        end else begin
            chk({tag, "_rd_data"}, 32'(rd_data), 32'(ref_q[$]));
            void'(ref_q.pop_back());
            rd_req[w-2] = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_ack_clear"}, 32'({rd_ack, wr_ack}), 0);
        chk({tag, "_busy_clear"}, 32'(busy), 0);
        if (reraise) begin
            if (w < 2) wr_req[w] = 1'b1;
            else rd_req[w-2] = 1'b1;
        end
    endtask

    initial begin
        int n, start;
        bit got, ackseen;

        rst = 1'b1;
        wr_req = 2'b00; rd_req = 2'b00;
        wr_data0 = '0; wr_data1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_rdy", 32'(tx_rdy), 0);
        chk("rst_rx_done", 32'(rx_done), 0);
        chk("rst_in_data", 32'(in_data), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_acks", 32'({rd_ack, wr_ack}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'({err_id, err}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Push then pop.
        wr_data0 = 8'h5A; wr_req[0] = 1'b1;
        run_txn("pp_push", 0);
        rd_req[0] = 1'b1;
        run_txn("pp_pop", 0);

        // Round-robin between two continuous writers, then LIFO pops.
        wr_data0 = 8'h11; wr_data1 = 8'h22;
        wr_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            chk("rr_order", 32'(predict()), 32'(i % 2));
            run_txn("rr_push", 1);
        end
        wr_req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            rd_req[0] = 1'b1;
            chk("rr_pop_val", 32'(ref_q[$]), (i % 2 == 0) ? 32'h22 : 32'h11);
            run_txn("rr_pop", 0);
        end

        // Empty mask.
        rd_req[0] = 1'b1;
        run_txn("empty_mask", 0);
        wr_data0 = 8'h07; wr_req[0] = 1'b1;
        run_txn("empty_push", 0);
        chk("empty_rd_grant", 32'(predict()), 2);
        run_txn("empty_pop", 0);
        chk("empty_rd_val", 32'(rd_data), 32'h07);

        // Full mask.
        for (int i = 0; i < DEPTH; i++) begin
            wr_data0 = 8'($urandom); wr_req[0] = 1'b1;
            run_txn("fill", 0);
        end
        @(negedge clk);
        chk("full_flag", 32'(full), 1);
        wr_data1 = 8'($urandom); wr_req[1] = 1'b1; rd_req[1] = 1'b1;
        chk("full_r1_first", 32'(predict()), 3);
        run_txn("full_pop", 0);
        chk("full_w1_next", 32'(predict()), 1);
        run_txn("full_push", 0);
        rd_req[0] = 1'b1;
        run_txn("full_drain", 0);

        // Watchdog on a stalled push from W1.
        stall_tx = 1;
        wr_data1 = 8'hC3; wr_req[1] = 1'b1;
        start = -1; got = 0; ackseen = 0;
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            if (busy && start < 0) start = n;
            if (wr_ack != 0) ackseen = 1;
            if (err) begin got = 1; break; end
        end
        chk("wd_err_seen", 32'(got), 1);
        chk("wd_cycles", 32'(n - start), 16);
        chk("wd_err_id", 32'(err_id), 1);
        chk("wd_tx_rdy", 32'(tx_rdy), 0);
        chk("wd_no_ack", 32'(ackseen), 0);
        wr_req[1] = 1'b0;
        last_m = 1;
        @(negedge clk);
        chk("wd_err_clear", 32'(err), 0);
        chk("wd_idle", 32'(busy), 0);
        stall_tx = 0;
        @(negedge clk);

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            if (!wr_req[0] && $urandom_range(1, 0) == 1) begin wr_data0 = 8'($urandom); wr_req[0] = 1'b1; end
            if (!wr_req[1] && $urandom_range(1, 0) == 1) begin wr_data1 = 8'($urandom); wr_req[1] = 1'b1; end
            if (!rd_req[0] && $urandom_range(2, 0) == 0) rd_req[0] = 1'b1;
            if (!rd_req[1] && $urandom_range(2, 0) == 0) rd_req[1] = 1'b1;
            run_txn("rand", 0);
        end
        wr_req = 2'b00; rd_req = 2'b00;
        @(negedge clk);

        // Reset during RD_REL.
        if (ref_q.size() == 0) begin
            wr_data0 = 8'h3C; wr_req[0] = 1'b1;
            run_txn("rst_prep", 0);
        end
        rd_req[0] = 1'b1;
        got = 0;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rx_done) begin got = 1; break; end
        end
        chk("rst_mid_reached", 32'(got), 1);
        rst = 1'b1;
        void'(ref_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        rd_req[0] = 1'b0;
        last_m = 3;
        chk("rst_mid_rx_done", 32'(rx_done), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_rd_ack", 32'(rd_ack), 0);
        wr_data0 = 8'hA1; wr_data1 = 8'hB2;
        wr_req = 2'b11; rd_req = 2'b11;
        chk("rst_first_grant", 32'(predict()), 0);
        run_txn("rst_w0", 0);
        wr_req = 2'b00; rd_req = 2'b00;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
